// File: rtl/prog_mem.sv
// Program memory reloaded by a serial bit stream; the CPU fetches from it when not held.
// Latency: fetch data is combinational from addr; a loaded word lands on the edge of its last bit.
// Backpressure: ld_ready is high only while loading; cpu_hold keeps the CPU in reset during a load.
module prog_mem #(
   parameter int ADDR_W = 1,
   parameter int DATA_W = 1,
   parameter logic [DATA_W-1:0] INIT = '0
) (
   input  logic              clk,
   input  logic              n_rst,
   input  logic [ADDR_W-1:0] addr,
   output logic [DATA_W-1:0] data,
   input  logic              ld_start,
   input  logic              ld_valid,
   input  logic              ld_bit,
   input  logic              ld_abort,
   output logic              ld_ready,
   output logic              ld_done,
   output logic              ld_err,
   output logic              cpu_hold
);

   localparam int DEPTH = 1 << ADDR_W;
   // Bit counter needs at least one bit even for single-bit words.
   localparam int BCW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [BCW-1:0]    BIT_LAST  = BCW'(DATA_W - 1);
   localparam logic [ADDR_W-1:0] WORD_LAST = '1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOAD,
      S_DONE
   } state_t;

   state_t             state_q, state_d;
   logic [BCW-1:0]     bit_cnt_q, bit_cnt_d;
   logic [ADDR_W-1:0]  word_cnt_q, word_cnt_d;
   logic [DATA_W-1:0]  shift_q, shift_d;
   logic               ld_err_q, ld_err_d;
   logic [DATA_W-1:0]  mem_q [DEPTH];
   logic [DATA_W-1:0]  mem_d [DEPTH];
   logic [DATA_W-1:0]  word_new;

   // Next-state, load assembly and memory write selection.
   always_comb begin
      state_d    = state_q;
      bit_cnt_d  = bit_cnt_q;
      word_cnt_d = word_cnt_q;
      shift_d    = shift_q;
      ld_err_d   = ld_err_q;
      mem_d      = mem_q;
      // Earlier bits move up one place; the incoming bit lands in the LSB.
      word_new   = (shift_q << 1) | DATA_W'(ld_bit);
      case (state_q)
         S_IDLE: begin
            if (ld_start) begin
               state_d    = S_LOAD;
               ld_err_d   = 1'b0;
               bit_cnt_d  = '0;
               word_cnt_d = '0;
               shift_d    = '0;
            end
         end
         S_LOAD: begin
            // Abort wins over a bit offered on the same edge; words already written stay.
            if (ld_abort) begin
               state_d    = S_IDLE;
               ld_err_d   = 1'b1;
               bit_cnt_d  = '0;
               word_cnt_d = '0;
               shift_d    = '0;
            end else if (ld_valid) begin
               if (bit_cnt_q == BIT_LAST) begin
                  mem_d[word_cnt_q] = word_new;
                  bit_cnt_d         = '0;
                  shift_d           = '0;
                  word_cnt_d        = word_cnt_q + ADDR_W'(1);
                  if (word_cnt_q == WORD_LAST) begin
                     state_d = S_DONE;
                  end
               end else begin
                  shift_d   = word_new;
                  bit_cnt_d = bit_cnt_q + BCW'(1);
               end
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and memory registers; reset overrides everything on the same edge.
   always_ff @(posedge clk) begin
      if (n_rst) begin
         state_q    <= S_IDLE;
         bit_cnt_q  <= '0;
         word_cnt_q <= '0;
         shift_q    <= '0;
         ld_err_q   <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= INIT;
         end
      end else begin
         state_q    <= state_d;
         bit_cnt_q  <= bit_cnt_d;
         word_cnt_q <= word_cnt_d;
         shift_q    <= shift_d;
         ld_err_q   <= ld_err_d;
         mem_q      <= mem_d;
      end
   end

   assign ld_ready = (state_q == S_LOAD);
   assign ld_done  = (state_q == S_DONE);
   assign cpu_hold = (state_q != S_IDLE);
   assign ld_err   = ld_err_q;
   // Memory is unstable while held, so the CPU sees zeros instead of half-loaded words.
   assign data     = cpu_hold ? '0 : mem_q[addr];

endmodule

// File: tb/tb_prog_mem.sv
module tb_prog_mem;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Instance A: default parameters (1-bit address, 1-bit words, INIT 0).
   logic       a_rst, a_start, a_valid, a_bit, a_abort;
   logic [0:0] a_addr, a_data;
   logic       a_ready, a_done, a_err, a_hold;

   // Instance B: 4 words of 4 bits, INIT 0.
   logic       b_rst, b_start, b_valid, b_bit, b_abort;
   logic [1:0] b_addr;
   logic [3:0] b_data;
   logic       b_ready, b_done, b_err, b_hold;
   int         b_done_cnt;

   prog_mem u_a (
      .clk(clk), .n_rst(a_rst), .addr(a_addr), .data(a_data),
      .ld_start(a_start), .ld_valid(a_valid), .ld_bit(a_bit), .ld_abort(a_abort),
      .ld_ready(a_ready), .ld_done(a_done), .ld_err(a_err), .cpu_hold(a_hold)
   );

   prog_mem #(.ADDR_W(2), .DATA_W(4), .INIT(4'h0)) u_b (
      .clk(clk), .n_rst(b_rst), .addr(b_addr), .data(b_data),
      .ld_start(b_start), .ld_valid(b_valid), .ld_bit(b_bit), .ld_abort(b_abort),
      .ld_ready(b_ready), .ld_done(b_done), .ld_err(b_err), .cpu_hold(b_hold)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic a_word(input string tag, input logic idx, input logic exp);
      a_addr = idx;
      #1;
      check(tag, 32'(a_data), 32'(exp));
   endtask

   task automatic b_word(input string tag, input logic [1:0] idx, input logic [3:0] exp);
      b_addr = idx;
      #1;
      check(tag, 32'(b_data), 32'(exp));
   endtask

   // Stream 16 bits MSB first into B (already in LOAD), optional idle cycle after bit gap_after.
   task automatic b_send(input logic [15:0] pat, input int gap_after);
      for (int i = 0; i < 16; i++) begin
         b_valid = 1'b1;
         b_bit   = pat[15-i];
         tick();
         if (b_done) b_done_cnt++;
         if (i + 1 == gap_after) begin
            b_valid = 1'b0;
            tick();
            if (b_done) b_done_cnt++;
            check("b_gap_hold", 32'(b_hold), 32'd1);
            check("b_gap_ready", 32'(b_ready), 32'd1);
         end
      end
      b_valid = 1'b0;
      b_bit   = 1'b0;
      tick();
      if (b_done) b_done_cnt++;
   endtask

   initial begin
      a_rst = 1'b1; a_start = 1'b0; a_valid = 1'b0; a_bit = 1'b0; a_abort = 1'b0; a_addr = 1'b0;
      b_rst = 1'b1; b_start = 1'b0; b_valid = 1'b0; b_bit = 1'b0; b_abort = 1'b0; b_addr = 2'd0;
      b_done_cnt = 0;

      // Reset defaults
      tick();
      a_rst = 1'b0;
      b_rst = 1'b0;
      a_word("a_rst_data0", 1'b0, 1'b0);
      a_word("a_rst_data1", 1'b1, 1'b0);
      check("a_rst_ready", 32'(a_ready), 32'd0);
      check("a_rst_hold",  32'(a_hold),  32'd0);
      check("a_rst_err",   32'(a_err),   32'd0);
      check("a_rst_done",  32'(a_done),  32'd0);

      // Default load: bits 1,0
      a_start = 1'b1;
      tick();
      a_start = 1'b0;
      check("a_ld_hold",  32'(a_hold),  32'd1);
      check("a_ld_ready", 32'(a_ready), 32'd1);
      a_word("a_ld_data_held", 1'b0, 1'b0);
      a_valid = 1'b1; a_bit = 1'b1;
      tick();
      check("a_ld_done_early", 32'(a_done), 32'd0);
      a_bit = 1'b0;
      tick();
      a_valid = 1'b0;
      check("a_ld_done",      32'(a_done),  32'd1);
      check("a_ld_done_hold", 32'(a_hold),  32'd1);
      check("a_ld_done_rdy",  32'(a_ready), 32'd0);
      tick();
      check("a_idle_done", 32'(a_done), 32'd0);
      check("a_idle_hold", 32'(a_hold), 32'd0);
      a_word("a_ld_word0", 1'b0, 1'b1);
      a_word("a_ld_word1", 1'b1, 1'b0);

      // Abort while idle is ignored
      a_abort = 1'b1;
      tick();
      a_abort = 1'b0;
      check("a_ign_abort_err",  32'(a_err),   32'd0);
      check("a_ign_abort_rdy",  32'(a_ready), 32'd0);
      a_word("a_ign_abort_word0", 1'b0, 1'b1);

      // Start held during LOAD is ignored
      a_start = 1'b1;
      tick();
      tick();
      check("a_ign_start_rdy",  32'(a_ready), 32'd1);
      check("a_ign_start_done", 32'(a_done),  32'd0);
      a_start = 1'b0;

      // One accepted bit, then reset (with start also high) abandons the load
      a_valid = 1'b1; a_bit = 1'b1;
      tick();
      check("a_mid_rdy", 32'(a_ready), 32'd1);
      a_valid = 1'b0; a_bit = 1'b0;
      a_rst = 1'b1; a_start = 1'b1;
      tick();
      a_rst = 1'b0; a_start = 1'b0;
      check("a_mid_rst_err",  32'(a_err),   32'd0);
      check("a_mid_rst_rdy",  32'(a_ready), 32'd0);
      check("a_mid_rst_hold", 32'(a_hold),  32'd0);
      a_word("a_mid_rst_word0", 1'b0, 1'b0);
      a_word("a_mid_rst_word1", 1'b1, 1'b0);

      // B: 16-bit load with a gap after bit 5
      b_word("b_rst_word3", 2'd3, 4'h0);
      b_start = 1'b1;
      tick();
      b_start = 1'b0;
      check("b_start_rdy", 32'(b_ready), 32'd1);
      b_done_cnt = 0;
      b_send(16'hA5F0, 5);
      check("b_done_once", 32'(b_done_cnt), 32'd1);
      check("b_load_hold", 32'(b_hold), 32'd0);
      check("b_load_err",  32'(b_err),  32'd0);
      b_word("b_load_word0", 2'd0, 4'hA);
      b_word("b_load_word1", 2'd1, 4'h5);
      b_word("b_load_word2", 2'd2, 4'hF);
      b_word("b_load_word3", 2'd3, 4'h0);

      // B: abort together with bit 6 after reset to zero
      b_rst = 1'b1;
      tick();
      b_rst = 1'b0;
      b_start = 1'b1;
      tick();
      b_start = 1'b0;
      b_valid = 1'b1;
      b_bit = 1'b1; tick();
      b_bit = 1'b1; tick();
      b_bit = 1'b0; tick();
      b_bit = 1'b0; tick();
      b_bit = 1'b1; tick();
      b_bit = 1'b1; b_abort = 1'b1; tick();
      b_valid = 1'b0; b_bit = 1'b0; b_abort = 1'b0;
      check("b_abort_err",  32'(b_err),   32'd1);
      check("b_abort_hold", 32'(b_hold),  32'd0);
      check("b_abort_rdy",  32'(b_ready), 32'd0);
      b_word("b_abort_word0", 2'd0, 4'hC);
      b_word("b_abort_word1", 2'd1, 4'h0);

      // New start clears the error and the load restarts from word 0, bit 0
      b_start = 1'b1;
      tick();
      b_start = 1'b0;
      check("b_restart_err", 32'(b_err),   32'd0);
      check("b_restart_rdy", 32'(b_ready), 32'd1);
      b_done_cnt = 0;
      b_send(16'h1234, 0);
      check("b_reload_done", 32'(b_done_cnt), 32'd1);
      b_word("b_reload_word0", 2'd0, 4'h1);
      b_word("b_reload_word1", 2'd1, 4'h2);
      b_word("b_reload_word2", 2'd2, 4'h3);
      b_word("b_reload_word3", 2'd3, 4'h4);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/prog_mem.md
PROG_MEM -- requirements
Module: prog_mem

Interface
REQ-001 Parameter ADDR_W, default 1: width of the CPU program address; depth is 2^ADDR_W words.
REQ-002 Parameter DATA_W, default 1: width of one program word.
REQ-003 Parameter INIT, default 0: DATA_W-bit value every word takes on reset.
REQ-004 clk  in  1  single clock; all state updates on the rising edge.
REQ-005 n_rst  in  1  reset, synchronous, active-high; the block resets on any rising clk edge where n_rst=1.
REQ-006 addr  in  ADDR_W  CPU fetch address.
REQ-007 data  out  DATA_W  program word returned to the CPU.
REQ-008 ld_start  in  1  request to begin a full-memory serial load.
REQ-009 ld_valid  in  1  ld_bit is valid this cycle.
REQ-010 ld_bit  in  1  serial load data.
REQ-011 ld_abort  in  1  cancel an active load.
REQ-012 ld_ready  out  1  the block accepts ld_bit this cycle.
REQ-013 ld_done  out  1  one-cycle pulse marking a completed load.
REQ-014 ld_err  out  1  sticky flag marking an aborted load.
REQ-015 cpu_hold  out  1  high while program memory is unstable; the CPU treats it as reset.

Function
REQ-016 The block SHALL have states IDLE, LOAD and DONE.
REQ-017 IDLE SHALL go to LOAD on the next edge when ld_start=1; ld_err SHALL clear on that same edge.
REQ-018 ld_ready SHALL be 1 exactly when the state is LOAD, combinationally from state.
REQ-019 A bit SHALL be accepted on every edge where ld_valid=1 and ld_ready=1; bits with ld_valid=0 SHALL be ignored, so gaps are allowed.
REQ-020 Bits SHALL fill each word MSB first, words in order starting at address 0.
REQ-021 A shift register and a bit counter (0..DATA_W-1) SHALL assemble each word.
REQ-022 The word SHALL be written to memory on the same edge its last bit is accepted, including that bit.
REQ-023 The word counter SHALL then increment, wrapping to 0 after 2^ADDR_W-1.
REQ-024 On the edge that writes the last word (address 2^ADDR_W-1), the state SHALL go LOAD->DONE.
REQ-025 ld_done SHALL be 1 for exactly the one cycle spent in DONE; DONE SHALL go to IDLE on the next edge.
REQ-026 ld_abort=1 in LOAD SHALL go to IDLE on the next edge and set ld_err=1.
REQ-027 Words written before an abort SHALL keep their new values; the partial word SHALL be discarded and the counters cleared.
REQ-028 ld_abort SHALL take priority over a bit accepted on the same edge; that bit SHALL not be written.
REQ-029 ld_start in LOAD or DONE SHALL be ignored; ld_abort outside LOAD SHALL be ignored.
REQ-030 cpu_hold SHALL be 1 in LOAD and DONE and 0 in IDLE.
REQ-031 data SHALL be a combinational read of mem[addr] when cpu_hold=0, and all-zero when cpu_hold=1.
REQ-032 A same-cycle read of a word being written SHALL return the old value until the edge.
REQ-033 Each load SHALL start at word 0 with the bit counter at 0.

Reset
REQ-034 On reset every memory word SHALL become INIT and the state SHALL become IDLE.
REQ-035 On reset the bit counter, word counter and shift register SHALL become 0.
REQ-036 On reset the outputs SHALL become ld_ready=0, ld_done=0, ld_err=0 and cpu_hold=0, with data=INIT.
REQ-037 A reset during LOAD SHALL abandon the load without setting ld_err.
REQ-038 Reset SHALL take priority over every other input on the same edge.

Verification
REQ-039 Reset, defaults: n_rst=1 for 1 edge, then 0 -> data=0 for addr 0 and 1; ld_ready=0, cpu_hold=0, ld_err=0.
REQ-040 Default load: ld_start pulse, then bits 1,0 on consecutive cycles.
 -> cpu_hold=1 from the cycle after start.
 -> ld_done=1 in the cycle after the 2nd bit.
 -> then IDLE with data=1 at addr=0 and data=0 at addr=1.
REQ-041 ADDR_W=2, DATA_W=4: load 16 bits 1010_0101_1111_0000 with one ld_valid=0 gap after bit 5.
 -> words read back 0xA, 0x5, 0xF, 0x0.
 -> ld_done pulses exactly once.
REQ-042 Abort: ADDR_W=2, DATA_W=4, memory preloaded 0, abort asserted together with bit 6.
 -> word0 holds the new value, word1 stays 0.
 -> ld_err=1, state IDLE, cpu_hold=0.
 -> a new ld_start clears ld_err.
REQ-043 Reset mid-load (default parameters): n_rst=1 after one accepted bit -> all words INIT, ld_err=0, ld_ready=0.
REQ-044 Ignored controls: ld_start during LOAD and ld_abort in IDLE -> no state change and no memory change.
